// File: rtl/tone_frequency_detector.sv
// Measures the period between hysteretic rising midpoint crossings of a sample
// stream and converts it into a phase-increment word with a serial divider.
module tone_frequency_detector #(
  parameter int SAMPLE_BITS      = 12,
  parameter int FREQ_BITS        = 16,
  parameter int ACCUMULATOR_BITS = 24,
  parameter int PERIOD_BITS      = 24,
  parameter int HYST             = 256
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [SAMPLE_BITS-1:0] din,
  output logic [FREQ_BITS-1:0]   freq_out,
  output logic [PERIOD_BITS-1:0] period_out,
  output logic                   freq_valid,
  output logic                   locked,
  output logic                   busy
);

  localparam int MID = 2 ** (SAMPLE_BITS - 1);
  localparam logic [SAMPLE_BITS:0]   HI_TH    = (SAMPLE_BITS + 1)'(MID + HYST);
  localparam logic [SAMPLE_BITS-1:0] LO_TH    = SAMPLE_BITS'(MID - HYST);
  localparam logic [PERIOD_BITS-1:0] CNT_MAX  = '1;
  localparam int                     QW       = ACCUMULATOR_BITS + 1;
  localparam int                     BW       = $clog2(QW);
  localparam logic [BW-1:0]          LAST_BIT = BW'(ACCUMULATOR_BITS);
  localparam logic [QW-1:0]          FREQ_MAX = QW'((2 ** FREQ_BITS) - 1);

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

  state_t                 state_q, state_d;
  logic                   hi_q, hi_d;
  logic                   armed_q, armed_d;
  logic                   locked_q, locked_d;
  logic                   valid_q, valid_d;
  logic                   rise, timeout, measure;
  logic [PERIOD_BITS-1:0] cnt_q, cnt_d;
  logic [PERIOD_BITS-1:0] p_q, p_d;
  logic [PERIOD_BITS-1:0] period_q, period_d;
  logic [PERIOD_BITS:0]   rem_q, rem_d;
  logic [PERIOD_BITS+1:0] shifted, diff;
  logic [QW-1:0]          q_q, q_d;
  logic [BW-1:0]          bit_q, bit_d;
  logic [FREQ_BITS-1:0]   freq_q, freq_d;

  // Crossing detection, period counting and timeout run regardless of divider state.
  always_comb begin
    hi_d = hi_q;
    if ({1'b0, din} >= HI_TH) begin
      hi_d = 1'b1;
    end else if (din <= LO_TH) begin
      hi_d = 1'b0;
    end
    rise = hi_d & ~hi_q;

    if (rise) begin
      cnt_d = PERIOD_BITS'(1);
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + PERIOD_BITS'(1);
    end
    timeout = (cnt_q != CNT_MAX) && (cnt_d == CNT_MAX);

    armed_d = armed_q;
    if (rise) begin
      armed_d = 1'b1;
    end else if (timeout) begin
      armed_d = 1'b0;
    end
    measure = rise & armed_q & (state_q == IDLE);
  end

  always_comb begin
    state_d  = state_q;
    p_d      = p_q;
    rem_d    = rem_q;
    q_d      = q_q;
    bit_d    = bit_q;
    freq_d   = freq_q;
    period_d = period_q;
    valid_d  = 1'b0;
    locked_d = locked_q;

    // The dividend is a single one followed by ACCUMULATOR_BITS zeros; the top
    // bit of the difference doubles as the restoring-division borrow.
    shifted = {rem_q, (bit_q == LAST_BIT)};
    diff    = shifted - {2'b00, p_q};

    if (timeout) begin
      locked_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (measure) begin
          p_d     = cnt_q;
          rem_d   = '0;
          q_d     = '0;
          bit_d   = LAST_BIT;
          state_d = DIV;
        end
      end
      DIV: begin
        rem_d = diff[PERIOD_BITS+1] ? shifted[PERIOD_BITS:0] : diff[PERIOD_BITS:0];
        q_d   = {q_q[QW-2:0], ~diff[PERIOD_BITS+1]};
        if (bit_q == '0) begin
          state_d = DONE;
        end else begin
          bit_d = bit_q - BW'(1);
        end
      end
      DONE: begin
        freq_d   = (q_q > FREQ_MAX) ? '1 : q_q[FREQ_BITS-1:0];
        period_d = p_q;
        valid_d  = 1'b1;
        locked_d = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      hi_q     <= 1'b0;
      armed_q  <= 1'b0;
      locked_q <= 1'b0;
      valid_q  <= 1'b0;
      cnt_q    <= '0;
      p_q      <= '0;
      period_q <= '0;
      rem_q    <= '0;
      q_q      <= '0;
      bit_q    <= '0;
      freq_q   <= '0;
    end else begin
      state_q  <= state_d;
      hi_q     <= hi_d;
      armed_q  <= armed_d;
      locked_q <= locked_d;
      valid_q  <= valid_d;
      cnt_q    <= cnt_d;
      p_q      <= p_d;
      period_q <= period_d;
      rem_q    <= rem_d;
      q_q      <= q_d;
      bit_q    <= bit_d;
      freq_q   <= freq_d;
    end
  end

  assign freq_out   = freq_q;
  assign period_out = period_q;
  assign freq_valid = valid_q;
  assign locked     = locked_q;
  assign busy       = (state_q == DIV);

endmodule

// File: tb/tb_tone_frequency_detector.sv
// Self-checking bench for tone_frequency_detector: scenario tasks compared
// against a cycle-stamped event model of crossings and measurements.
module tb_tone_frequency_detector;

  localparam int     HI    = 2048 + 256;
  localparam int     LO    = 2048 - 256;
  localparam longint MAX24 = 64'd16777215;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] din = '0;

  logic [15:0] freq_out;
  logic [23:0] period_out;
  logic        freq_valid, locked, busy;
  logic [15:0] freq16;
  logic [15:0] period16;
  logic        fv16, locked16, busy16;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  tone_frequency_detector #(
    .SAMPLE_BITS(12), .FREQ_BITS(16), .ACCUMULATOR_BITS(24), .PERIOD_BITS(24), .HYST(256)
  ) dut (
    .clk(clk), .rst(rst), .din(din), .freq_out(freq_out), .period_out(period_out),
    .freq_valid(freq_valid), .locked(locked), .busy(busy)
  );

  tone_frequency_detector #(
    .SAMPLE_BITS(12), .FREQ_BITS(16), .ACCUMULATOR_BITS(24), .PERIOD_BITS(16), .HYST(256)
  ) dut16 (
    .clk(clk), .rst(rst), .din(din), .freq_out(freq16), .period_out(period16),
    .freq_valid(fv16), .locked(locked16), .busy(busy16)
  );

  // Reference model: timestamps crossings and schedules each accepted
  // measurement to appear 27 cycles after its edge.
  typedef struct {
    longint due;
    longint per;
    longint frq;
  } meas_t;

  meas_t       exp_q[$];
  longint      cyc        = 0;
  longint      last_edge  = -1;
  longint      busy_until = 0;
  bit          m_hi       = 1'b0;
  bit          m_locked   = 1'b0;
  bit          exp_fv     = 1'b0;
  bit          exp_busy   = 1'b0;
  logic [15:0] exp_freq   = '0;
  logic [23:0] exp_per    = '0;

  always @(posedge clk) begin : ref_model
    int     dv;
    bit     nh;
    longint p;
    longint f;
    meas_t  m;
    if (rst) begin
      m_hi       = 1'b0;
      last_edge  = -1;
      busy_until = 0;
      exp_q.delete();
      m_locked   = 1'b0;
      exp_freq   = '0;
      exp_per    = '0;
    end else begin
      dv = int'(din);
      nh = m_hi;
      if (dv >= HI) nh = 1'b1;
      else if (dv <= LO) nh = 1'b0;
      if (nh && !m_hi) begin
        if (last_edge >= 0 && (cyc - last_edge) < MAX24 && cyc >= busy_until) begin
          p = cyc - last_edge;
          f = (longint'(1) << 24) / p;
          if (f > 65535) f = 65535;
          m.due = cyc + 27;
          m.per = p;
          m.frq = f;
          exp_q.push_back(m);
          busy_until = cyc + 27;
        end
        last_edge = cyc;
      end
      m_hi = nh;
    end
    cyc++;
    exp_fv   = 1'b0;
    exp_busy = 1'b0;
    if (!rst) begin
      if (last_edge >= 0 && (cyc - last_edge) == MAX24) m_locked = 1'b0;
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        exp_fv   = 1'b1;
        exp_freq = 16'(exp_q[0].frq);
        exp_per  = 24'(exp_q[0].per);
        m_locked = 1'b1;
        exp_q.pop_front();
      end
      if (exp_q.size() > 0 && cyc >= exp_q[0].due - 26 && cyc <= exp_q[0].due - 2)
        exp_busy = 1'b1;
    end
  end

  task automatic step(input logic [11:0] v);
    din = v;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(12'h000);
    step(12'h000);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({freq_valid, busy, locked} !== 3'b000)
      $display("[TB] FAIL reset_flags got %b expected 000", {freq_valid, busy, locked});
    else n_pass++;
    n_checks++;
    if (freq_out !== 16'h0000)
      $display("[TB] FAIL reset_freq got %h expected 0000", freq_out);
    else n_pass++;
    n_checks++;
    if (period_out !== 24'h000000)
      $display("[TB] FAIL reset_period got %h expected 000000", period_out);
    else n_pass++;
    n_checks++;
    if ({fv16, busy16, locked16, freq16, period16} !== 35'd0)
      $display("[TB] FAIL reset_dut16 got fv=%b busy=%b lock=%b f=%h p=%h expected all zero",
               fv16, busy16, locked16, freq16, period16);
    else n_pass++;
  endtask

  task automatic test_sawtooth();
    int pulses = 0;
    do_reset();
    for (int t = 0; t < 8400; t++) begin
      step(12'((2200 + t) % 4096));
      n_checks++;
      if ({freq_valid, busy, locked} !== {exp_fv, exp_busy, m_locked})
        $display("[TB] FAIL saw_flags t=%0d got fv/busy/lock=%b expected %b", t,
                 {freq_valid, busy, locked}, {exp_fv, exp_busy, m_locked});
      else n_pass++;
      n_checks++;
      if ({freq_out, period_out} !== {exp_freq, exp_per})
        $display("[TB] FAIL saw_result t=%0d got f=%h p=%0d expected f=%h p=%0d", t,
                 freq_out, period_out, exp_freq, exp_per);
      else n_pass++;
      if (freq_valid === 1'b1) begin
        pulses++;
        n_checks++;
        if (period_out !== 24'd4096 || freq_out !== 16'h1000 || locked !== 1'b1)
          $display("[TB] FAIL saw_pulse got p=%0d f=%h lock=%b expected p=4096 f=1000 lock=1",
                   period_out, freq_out, locked);
        else n_pass++;
      end
    end
    n_checks++;
    if (pulses != 2) $display("[TB] FAIL saw_count got %0d pulses expected 2", pulses);
    else n_pass++;
  endtask

  task automatic test_square(input int per, input int steps, input int want_pulses,
                             input logic [15:0] want_f);
    int pulses = 0;
    logic [11:0] v;
    do_reset();
    for (int t = 0; t < steps; t++) begin
      if (t < 10) v = 12'h000;
      else v = (((t - 10) % per) < per / 2) ? 12'hFFF : 12'h000;
      step(v);
      n_checks++;
      if ({freq_valid, busy, locked} !== {exp_fv, exp_busy, m_locked})
        $display("[TB] FAIL sq%0d_flags t=%0d got %b expected %b", per, t,
                 {freq_valid, busy, locked}, {exp_fv, exp_busy, m_locked});
      else n_pass++;
      n_checks++;
      if ({freq_out, period_out} !== {exp_freq, exp_per})
        $display("[TB] FAIL sq%0d_result t=%0d got f=%0d p=%0d expected f=%0d p=%0d", per, t,
                 freq_out, period_out, exp_freq, exp_per);
      else n_pass++;
      if (freq_valid === 1'b1) begin
        pulses++;
        n_checks++;
        if (period_out !== 24'(per) || freq_out !== want_f)
          $display("[TB] FAIL sq%0d_pulse got p=%0d f=%0d expected p=%0d f=%0d", per,
                   period_out, freq_out, per, want_f);
        else n_pass++;
      end
    end
    n_checks++;
    if (pulses != want_pulses)
      $display("[TB] FAIL sq%0d_count got %0d expected %0d", per, pulses, want_pulses);
    else n_pass++;
  endtask

  task automatic test_hysteresis();
    int pulses = 0;
    do_reset();
    for (int t = 0; t < 300; t++) begin
      step(((t / 10) % 2) != 0 ? 12'(2048 - 100) : 12'(2048 + 100));
      n_checks++;
      if ({freq_valid, locked} !== 2'b00 || exp_fv != 1'b0)
        $display("[TB] FAIL hyst_quiet t=%0d got fv/lock=%b expected 00", t, {freq_valid, locked});
      else n_pass++;
    end
    for (int t = 0; t < 200; t++) begin
      step(((t / 10) % 2) != 0 ? 12'(2048 - 300) : 12'(2048 + 300));
      n_checks++;
      if ({freq_valid, busy, locked, freq_out, period_out} !==
          {exp_fv, exp_busy, m_locked, exp_freq, exp_per})
        $display("[TB] FAIL hyst_model t=%0d got fv=%b p=%0d expected fv=%b p=%0d", t,
                 freq_valid, period_out, exp_fv, exp_per);
      else n_pass++;
      if (freq_valid === 1'b1) begin
        pulses++;
        n_checks++;
        if (period_out !== 24'd20)
          $display("[TB] FAIL hyst_period got %0d expected 20", period_out);
        else n_pass++;
      end
    end
    n_checks++;
    if (pulses != 4) $display("[TB] FAIL hyst_count got %0d expected 4", pulses);
    else n_pass++;
  endtask

  task automatic test_random();
    int t = 0;
    int len;
    int kind;
    logic [11:0] v;
    do_reset();
    while (t < 3000) begin
      len  = int'($urandom_range(5, 400));
      kind = int'($urandom_range(0, 4));
      for (int k = 0; k < len && t < 3000; k++) begin
        case (kind)
          0, 1:    v = 12'($urandom_range(HI, 4095));
          2, 3:    v = 12'($urandom_range(0, LO));
          default: v = 12'($urandom_range(LO + 1, HI - 1));
        endcase
        step(v);
        t++;
        n_checks++;
        if ({freq_valid, busy, locked} !== {exp_fv, exp_busy, m_locked})
          $display("[TB] FAIL rand_flags t=%0d got %b expected %b", t,
                   {freq_valid, busy, locked}, {exp_fv, exp_busy, m_locked});
        else n_pass++;
        n_checks++;
        if ({freq_out, period_out} !== {exp_freq, exp_per})
          $display("[TB] FAIL rand_result t=%0d got f=%0d p=%0d expected f=%0d p=%0d", t,
                   freq_out, period_out, exp_freq, exp_per);
        else n_pass++;
      end
    end
  endtask

  task automatic test_reset_mid_div();
    int late = 0;
    logic [11:0] v;
    do_reset();
    for (int t = 0; t < 2100; t++) begin
      if (t < 10) v = 12'h000;
      else v = (((t - 10) % 1000) < 500) ? 12'hFFF : 12'h000;
      if (t == 2020) rst = 1'b1;
      step(v);
      rst = 1'b0;
      if (t == 2019) begin
        n_checks++;
        if (busy !== 1'b1) $display("[TB] FAIL middiv_busy got %b expected 1", busy);
        else n_pass++;
      end
      if (t == 2020) begin
        n_checks++;
        if ({busy, freq_valid, locked, freq_out, period_out} !== 43'd0)
          $display("[TB] FAIL middiv_reset got busy=%b fv=%b lock=%b f=%0d p=%0d expected all zero",
                   busy, freq_valid, locked, freq_out, period_out);
        else n_pass++;
      end
      if (t > 2020 && freq_valid === 1'b1) late++;
      n_checks++;
      if ({freq_valid, busy, locked, freq_out, period_out} !==
          {exp_fv, exp_busy, m_locked, exp_freq, exp_per})
        $display("[TB] FAIL middiv_model t=%0d got fv=%b busy=%b p=%0d expected fv=%b busy=%b p=%0d",
                 t, freq_valid, busy, period_out, exp_fv, exp_busy, exp_per);
      else n_pass++;
    end
    n_checks++;
    if (late != 0) $display("[TB] FAIL middiv_stale got %0d pulses expected 0", late);
    else n_pass++;
  endtask

  task automatic test_timeout();
    int e3 = 66645;
    int e4 = 66645 + 600;
    int pulses = 0;
    int c;
    logic [11:0] v;
    do_reset();
    for (int t = 0; t < e4 + 60; t++) begin
      if (t < 10) v = 12'h000;
      else if (t < 1510) v = (((t - 10) % 1000) < 500) ? 12'hFFF : 12'h000;
      else if (t < e3) v = 12'h000;
      else if (t < e3 + 300) v = 12'hFFF;
      else if (t < e4) v = 12'h000;
      else v = 12'hFFF;
      step(v);
      c = t + 1;
      if (fv16 === 1'b1) pulses++;
      if (c == 1037) begin
        n_checks++;
        if (fv16 !== 1'b1 || period16 !== 16'd1000 || freq16 !== 16'(16777216 / 1000))
          $display("[TB] FAIL to_lock got fv=%b p=%0d f=%0d expected fv=1 p=1000 f=%0d",
                   fv16, period16, freq16, 16777216 / 1000);
        else n_pass++;
      end
      if (c == 66544 || c == 66545) begin
        n_checks++;
        if (locked16 !== (c == 66544))
          $display("[TB] FAIL to_fall c=%0d got lock=%b expected %b", c, locked16, c == 66544);
        else n_pass++;
      end
      if (c == e4) begin
        n_checks++;
        if (locked16 !== 1'b0) $display("[TB] FAIL to_rearm got lock=%b expected 0", locked16);
        else n_pass++;
      end
      if (c == e4 + 27) begin
        n_checks++;
        if (fv16 !== 1'b1 || period16 !== 16'd600 || freq16 !== 16'(16777216 / 600) ||
            locked16 !== 1'b1)
          $display("[TB] FAIL to_relock got fv=%b p=%0d f=%0d lock=%b expected fv=1 p=600 f=%0d lock=1",
                   fv16, period16, freq16, locked16, 16777216 / 600);
        else n_pass++;
      end
    end
    n_checks++;
    if (pulses != 2) $display("[TB] FAIL to_count got %0d pulses expected 2", pulses);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_sawtooth();
    test_square(3000, 3050, 1, 16'd5592);
    test_square(200, 850, 4, 16'hFFFF);
    test_hysteresis();
    test_random();
    test_reset_mid_div();
    test_timeout();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
